branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Next-generation branch handling block: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Lookup side: fetch-stage prediction of taken/target for the current PC.
- Resolve side: takes execute-stage branch/jump outcomes, updates the table, flags mispredicts and supplies the redirect PC.
- Also keeps lookup/mispredict statistics counters for performance checks.

Parameters:
- PC_W, 9, program-counter width in bits; byte address, word aligned.
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- CTR_W, 2, width of each saturating direction counter; at least 1.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- F_PC  in  PC_W  fetch-stage PC to predict.
- Pred_Hit  out  1  BTB entry valid and tag match for F_PC.
- Pred_Taken  out  1  predicted taken (hit and counter MSB = 1).
- Pred_Target  out  32  stored target on hit; otherwise F_PC+4, zero-extended.
- Ex_Valid  in  1  execute-stage instruction valid (not a bubble).
- Ex_IsBranch  in  1  conditional branch in EX.
- Ex_IsJump  in  1  JAL/JALR in EX; always taken.
- Ex_PC  in  PC_W  PC of the EX instruction.
- Ex_Taken  in  1  resolved branch condition (ALU result bit 0).
- Ex_Target  in  32  resolved target (PC+Imm, or ALU result for JALR).
- Ex_PredTaken  in  1  prediction carried down the pipe with the instruction.
- Ex_PredTarget  in  32  predicted target carried down the pipe.
- Mispredict  out  1  EX outcome differs from the carried prediction.
- Redirect_PC  out  32  correct next PC when Mispredict = 1; otherwise 0.
- Stat_Branches  out  STAT_W  count of resolved branches and jumps.
- Stat_Mispredicts  out  STAT_W  count of mispredicts.

Behaviour:
- Derived widths:
  - IDX_W = log2(ENTRIES).
  - TAG_W = PC_W - IDX_W - 2; must be at least 1. Elaboration-time assertion otherwise.
- Address fields: index = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Entry contents: valid bit, TAG_W tag, 32-bit target, CTR_W counter. Held in flops, not RAM.
- Lookup:
  - Purely combinational from F_PC; zero latency.
  - Read-before-write: an update in cycle N becomes visible to lookup from cycle N+1.
  - Same-index lookup and update in one cycle returns the old contents.
- Resolve: active when Ex_Valid and (Ex_IsBranch or Ex_IsJump). Define ActTaken = Ex_IsJump or Ex_Taken.
- Mispredict (combinational) = active and (ActTaken != Ex_PredTaken, or ActTaken and Ex_PredTarget != Ex_Target).
- Redirect_PC:
  - ActTaken: Ex_Target.
  - Otherwise: zero-extended Ex_PC + 4.
  - 0 whenever Mispredict = 0.
- Table update at the clock edge when active:
  - Hit (valid and tag match at Ex_PC index):
    - Jump: counter set to all ones.
    - ActTaken: counter incremented, saturating at 2^CTR_W - 1.
    - Not taken: counter decremented, saturating at 0.
    - Target overwritten with Ex_Target when ActTaken.
  - Miss and ActTaken: allocate, replacing any occupant.
    - valid = 1, tag written, target = Ex_Target.
    - Counter = 2^(CTR_W-1) (weakly taken), or all ones for a jump.
  - Miss and not taken: no allocation; table unchanged.
- Statistics:
  - Stat_Branches increments on every active resolve.
  - Stat_Mispredicts increments when Mispredict = 1.
  - Both saturate at all ones; no wrap-around.
- Reset:
  - All valid bits, tags, targets, counters and statistics are cleared to 0 in one cycle.
  - Takes priority over a same-cycle update, including reset asserted mid-operation.
  - After reset: Pred_Hit = 0, Pred_Taken = 0, Pred_Target = F_PC+4.
  - Mispredict and Redirect_PC remain combinational functions of the EX inputs.
- Ex_IsBranch and Ex_IsJump both asserted is illegal; the assertion fires and the jump takes precedence.
- Ex_Valid = 0 suppresses updates, statistics and Mispredict.

Decomposition:
- Shared package (branch_pkg):
  - btb_entry_t struct (valid, tag, target, ctr).
  - Function sat_update(ctr, taken).
  - Constant PC_INC = 4.
- Sub-module sat_counter: parametrised CTR_W increment/decrement with saturation, reused for the direction counters.
- The statistics counters use inline saturating logic.

Test Plan:
- Reset then F_PC=0x010 -> Pred_Hit=0, Pred_Taken=0, Pred_Target=0x014; both statistics = 0.
- Taken branch resolve at Ex_PC=0x010, Ex_Target=0x040, Ex_PredTaken=0:
  - Same cycle: Mispredict=1, Redirect_PC=0x040.
  - Next cycle, F_PC=0x010: Hit=1, Taken=1, Target=0x040, ctr=2.
- Saturation, same entry (index 4, ctr=2):
  - Three more taken resolves: ctr=3 and stays 3.
  - Two not-taken resolves: ctr=1, Pred_Taken=0, Pred_Target=0x040.
  - Third not-taken: ctr=0.
- Target mismatch: jump at Ex_PC=0x020 with Ex_PredTaken=1, PredTarget=0x080, Ex_Target=0x0C0 -> Mispredict=1, Redirect_PC=0x0C0, entry updated to 0x0C0.
- Aliasing (ENTRIES=16): allocate 0x010 then taken 0x050 (same index, different tag) -> lookup of 0x010 misses, 0x050 hits; a not-taken miss at 0x090 leaves the 0x050 entry intact.
- Same-cycle lookup and update of 0x010, then reset asserted with Ex_Valid=1:
  - Lookup returns old data.
  - After the reset edge: all entries invalid, statistics 0, no update applied.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and helpers for the branch predict unit
//   PC_INC     - sequential fetch increment
//   btb_entry_t - one BTB entry; tag and counter are held at full word width
//                 so the struct stays independent of the unit's parameters
//   sat_update - saturating step of a direction counter towards taken/not-taken
package branch_pkg;
   localparam logic [31:0] PC_INC = 32'd4;
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      logic [31:0] ctr;
   } btb_entry_t;
   function automatic logic [31:0] sat_update(input logic [31:0] ctr, input logic taken, input logic [31:0] max);
      return taken ? ((ctr >= max) ? max : ctr + 32'd1) : ((ctr == 32'd0) ? 32'd0 : ctr - 32'd1);
   endfunction
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup, execute resolve and statistics bundle
//   master - pipeline side: drives F_PC and Ex_*, observes predictions/redirect/stats
//   slave  - predictor side
interface branch_predict_unit_if #(parameter int PC_W = 9, parameter int STAT_W = 32);
   logic [PC_W-1:0]   F_PC;
   logic              Pred_Hit;
   logic              Pred_Taken;
   logic [31:0]       Pred_Target;
   logic              Ex_Valid;
   logic              Ex_IsBranch;
   logic              Ex_IsJump;
   logic [PC_W-1:0]   Ex_PC;
   logic              Ex_Taken;
   logic [31:0]       Ex_Target;
   logic              Ex_PredTaken;
   logic [31:0]       Ex_PredTarget;
   logic              Mispredict;
   logic [31:0]       Redirect_PC;
   logic [STAT_W-1:0] Stat_Branches;
   logic [STAT_W-1:0] Stat_Mispredicts;
   modport master (
      output F_PC, Ex_Valid, Ex_IsBranch, Ex_IsJump, Ex_PC, Ex_Taken, Ex_Target, Ex_PredTaken, Ex_PredTarget,
      input  Pred_Hit, Pred_Taken, Pred_Target, Mispredict, Redirect_PC, Stat_Branches, Stat_Mispredicts
   );
   modport slave (
      input  F_PC, Ex_Valid, Ex_IsBranch, Ex_IsJump, Ex_PC, Ex_Taken, Ex_Target, Ex_PredTaken, Ex_PredTarget,
      output Pred_Hit, Pred_Taken, Pred_Target, Mispredict, Redirect_PC, Stat_Branches, Stat_Mispredicts
   );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: CTR_W-bit saturating up/down step of a direction counter
//   ctr   - current value (zero-extended to 32 bits)
//   taken - 1 increments towards 2^CTR_W-1, 0 decrements towards 0
//   nxt   - next value
module sat_counter
   import branch_pkg::*;
#(
   parameter int CTR_W = 2
) (
   input  logic [31:0] ctr,
   input  logic        taken,
   output logic [31:0] nxt
);
   localparam logic [31:0] CMAX = (32'd1 << CTR_W) - 32'd1;
   assign nxt = sat_update(ctr, taken, CMAX);
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating direction counters
//   clk, reset - clock and synchronous active-high reset
//   bus        - fetch lookup (F_PC -> Pred_*), execute resolve (Ex_* -> Mispredict,
//                Redirect_PC, table update) and saturating statistics
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int PC_W    = 9,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int STAT_W  = 32
) (
   input logic                  clk,
   input logic                  reset,
   branch_predict_unit_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [31:0] CMAX = (32'd1 << CTR_W) - 32'd1;
   localparam logic [31:0] HALF = 32'd1 << (CTR_W - 1);
   generate
      if (TAG_W < 1 || CTR_W < 1 || CTR_W > 31 || ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_cfg
         $error("branch_predict_unit: illegal PC_W/ENTRIES/CTR_W combination");
      end
   endgenerate
   btb_entry_t        tbl [ENTRIES];
   btb_entry_t        fe;
   logic [IDX_W-1:0]  f_idx, ex_idx;
   logic [31:0]       f_tag, ex_tag, ctr_nxt;
   logic              f_hit, ex_hit, active, act, jump, mp;
   logic [STAT_W-1:0] stat_br, stat_mp;
   always_comb begin
      f_idx  = bus.F_PC[IDX_W+1:2];
      f_tag  = 32'(bus.F_PC[PC_W-1:IDX_W+2]);
      ex_idx = bus.Ex_PC[IDX_W+1:2];
      ex_tag = 32'(bus.Ex_PC[PC_W-1:IDX_W+2]);
      fe     = tbl[f_idx];
      f_hit  = fe.valid && fe.tag == f_tag;
      ex_hit = tbl[ex_idx].valid && tbl[ex_idx].tag == ex_tag;
      jump   = bus.Ex_IsJump;
      act    = jump || bus.Ex_Taken;
      active = bus.Ex_Valid && (bus.Ex_IsBranch || jump);
      mp     = active && (act != bus.Ex_PredTaken || (act && bus.Ex_PredTarget != bus.Ex_Target));
   end
   // counter MSB test done as a compare so every stored counter bit participates
   assign bus.Pred_Hit         = f_hit;
   assign bus.Pred_Taken       = f_hit && fe.ctr >= HALF;
   assign bus.Pred_Target      = f_hit ? fe.target : 32'(bus.F_PC) + PC_INC;
   assign bus.Mispredict       = mp;
   assign bus.Redirect_PC      = !mp ? 32'd0 : act ? bus.Ex_Target : 32'(bus.Ex_PC) + PC_INC;
   assign bus.Stat_Branches    = stat_br;
   assign bus.Stat_Mispredicts = stat_mp;
   sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .ctr   (tbl[ex_idx].ctr),
      .taken (act),
      .nxt   (ctr_nxt)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
         stat_br <= '0;
         stat_mp <= '0;
      end else if (active) begin
         if (ex_hit) begin
            tbl[ex_idx].ctr <= jump ? CMAX : ctr_nxt;
            if (act) tbl[ex_idx].target <= bus.Ex_Target;
         end else if (act) begin
            tbl[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: bus.Ex_Target, ctr: jump ? CMAX : HALF};
         end
         stat_br <= stat_br + STAT_W'(stat_br != '1);
         stat_mp <= stat_mp + STAT_W'(mp && stat_mp != '1);
      end
   end
   // branch and jump together is illegal; the jump path above wins regardless
   a_branch_jump_excl: assert property (@(posedge clk) disable iff (reset)
      bus.Ex_Valid |-> !(bus.Ex_IsBranch && bus.Ex_IsJump));
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors with a scoreboard queue and negedge monitor
module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   branch_predict_unit_if #(.PC_W(9), .STAT_W(32)) bus ();
   branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CTR_W(2), .STAT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   typedef struct {
      int          id;
      logic        hit;
      logic        tk;
      logic [31:0] tgt;
      logic        mp;
      logic [31:0] rd;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int vid = 0;
   int nb = 0;
   int nm = 0;
   task automatic chk(input int id, input string nm_s, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL vec%0d %s actual=%h required=%h", id, nm_s, a, e);
      end
   endtask
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.id, "pred_hit", 32'(bus.Pred_Hit), 32'(e.hit));
         chk(e.id, "pred_taken", 32'(bus.Pred_Taken), 32'(e.tk));
         chk(e.id, "pred_target", bus.Pred_Target, e.tgt);
         chk(e.id, "mispredict", 32'(bus.Mispredict), 32'(e.mp));
         chk(e.id, "redirect_pc", bus.Redirect_PC, e.rd);
         chk(e.id, "stat_branches", bus.Stat_Branches, e.sb);
         chk(e.id, "stat_mispredicts", bus.Stat_Mispredicts, e.sm);
      end
   end
   task automatic drv(input logic rs, input logic [8:0] fpc, input logic v, input logic br, input logic jp,
                      input logic [8:0] xpc, input logic tk, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt, input logic eh, input logic et, input logic [31:0] etg,
                      input logic em, input logic [31:0] erd);
      @(posedge clk);
      #1;
      reset = rs;
      bus.F_PC = fpc;
      bus.Ex_Valid = v;
      bus.Ex_IsBranch = br;
      bus.Ex_IsJump = jp;
      bus.Ex_PC = xpc;
      bus.Ex_Taken = tk;
      bus.Ex_Target = tgt;
      bus.Ex_PredTaken = ptk;
      bus.Ex_PredTarget = ptgt;
      q.push_back('{id: vid, hit: eh, tk: et, tgt: etg, mp: em, rd: erd, sb: nb, sm: nm});
      vid++;
      if (rs) begin
         nb = 0;
         nm = 0;
      end else begin
         if (v && (br || jp)) nb++;
         if (em) nm++;
      end
   endtask
   task automatic idle(input logic [8:0] fpc, input logic eh, input logic et, input logic [31:0] etg);
      drv(1'b0, fpc, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0, 1'b0, 32'h0, eh, et, etg, 1'b0, 32'h0);
   endtask
   initial begin
      bus.F_PC = '0;
      bus.Ex_Valid = 1'b0;
      bus.Ex_IsBranch = 1'b0;
      bus.Ex_IsJump = 1'b0;
      bus.Ex_PC = '0;
      bus.Ex_Taken = 1'b0;
      bus.Ex_Target = '0;
      bus.Ex_PredTaken = 1'b0;
      bus.Ex_PredTarget = '0;
      repeat (2) @(posedge clk);
      idle(9'h010, 0, 0, 32'h014);
      drv(0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h040, 0, 32'h0,   0, 0, 32'h014, 1, 32'h040);
      idle(9'h010, 1, 1, 32'h040);
      repeat (3) drv(0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h040, 1, 32'h040, 1, 1, 32'h040, 0, 32'h0);
      repeat (2) drv(0, 9'h010, 1, 1, 0, 9'h010, 0, 32'h040, 1, 32'h040, 1, 1, 32'h040, 1, 32'h014);
      idle(9'h010, 1, 0, 32'h040);
      drv(0, 9'h010, 1, 1, 0, 9'h010, 0, 32'h040, 0, 32'h0,   1, 0, 32'h040, 0, 32'h0);
      idle(9'h010, 1, 0, 32'h040);
      drv(0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h040, 0, 32'h0,   1, 0, 32'h040, 1, 32'h040);
      idle(9'h010, 1, 0, 32'h040);
      drv(0, 9'h020, 1, 0, 1, 9'h020, 0, 32'h0C0, 1, 32'h080, 0, 0, 32'h024, 1, 32'h0C0);
      idle(9'h020, 1, 1, 32'h0C0);
      drv(0, 9'h020, 1, 0, 1, 9'h020, 0, 32'h100, 1, 32'h0C0, 1, 1, 32'h0C0, 1, 32'h100);
      idle(9'h020, 1, 1, 32'h100);
      drv(0, 9'h050, 1, 1, 0, 9'h050, 1, 32'h060, 0, 32'h0,   0, 0, 32'h054, 1, 32'h060);
      idle(9'h010, 0, 0, 32'h014);
      drv(0, 9'h050, 1, 1, 0, 9'h090, 0, 32'h0,   0, 32'h0,   1, 1, 32'h060, 0, 32'h0);
      idle(9'h050, 1, 1, 32'h060);
      drv(0, 9'h050, 0, 1, 0, 9'h050, 0, 32'h0,   1, 32'h060, 1, 1, 32'h060, 0, 32'h0);
      drv(0, 9'h050, 1, 0, 0, 9'h050, 1, 32'h0,   0, 32'h0,   1, 1, 32'h060, 0, 32'h0);
      drv(1, 9'h050, 1, 1, 0, 9'h050, 1, 32'h070, 1, 32'h060, 1, 1, 32'h060, 1, 32'h070);
      idle(9'h050, 0, 0, 32'h054);
      idle(9'h020, 0, 0, 32'h024);
      idle(9'h010, 0, 0, 32'h014);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
